// File: rtl/counter_bank_register_pkg.sv
// Shared constants and types for the counter bank register block.
package counter_bank_register_pkg;

  // Word offsets from BASE_ADDR
  localparam int CTRL_OFS   = 0;
  localparam int ENABLE_OFS = 1;
  localparam int OVF_OFS    = 2;
  localparam int CHAN_OFS   = 4;

  // CTRL write bits
  localparam int SNAP_BIT  = 0;
  localparam int CLEAR_BIT = 1;

  // Per-channel control strobes for one clock edge
  typedef struct packed {
    logic inc;
    logic en;
    logic clr;
    logic snap;
    logic ovf_clr;
  } chan_ctl_t;

endpackage

// File: rtl/counter_bank_register_if.sv
// Shared register bus. reg_data is a resolved tri-state net: the slave
// drives it only on a read hit, the master only while writing.
interface counter_bank_register_if;
  logic [15:0] reg_addr;
  logic        reg_wr;
  logic [31:0] wr_data;
  logic        wr_oe;
  logic [31:0] rd_data;
  logic        rd_oe;
  wire  [31:0] reg_data;

  assign reg_data = rd_oe ? rd_data : 'z;
  assign reg_data = wr_oe ? wr_data : 'z;

  modport master (output reg_addr, reg_wr, wr_data, wr_oe,
                  input  rd_data, rd_oe, reg_data);
  modport slave  (input  reg_addr, reg_wr, reg_data,
                  output rd_data, rd_oe);
endinterface

// File: rtl/counter_bank_register_channel.sv
// One channel: live counter, snapshot register and sticky overflow flag.
module counter_bank_channel
  import counter_bank_register_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  chan_ctl_t            ctl_i,
  output logic [CNT_WIDTH-1:0] snap_o,
  output logic                 ovf_o
);

  localparam logic [CNT_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, snap_q, snap_d;
  logic                 ovf_q, ovf_d;

  // Next state: clear beats increment; a new overflow beats W1C.
  // Snapshot always takes the pre-edge count, so SNAP|CLEAR loses nothing.
  always_comb begin
    cnt_d  = cnt_q;
    snap_d = ctl_i.snap ? cnt_q : snap_q;
    ovf_d  = ovf_q & ~ctl_i.ovf_clr;
    if (ctl_i.clr) begin
      cnt_d = '0;
    end else if (ctl_i.inc && ctl_i.en) begin
      if (cnt_q == ALL_ONES) begin
        cnt_d = (SATURATE != 0) ? ALL_ONES : '0;
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      snap_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign snap_o = snap_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/counter_bank_register.sv
// Bank of N_CHAN event counters on the shared register bus: address
// decode, ENABLE mask, read mux and tri-state read drive.
module counter_bank_register
  import counter_bank_register_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0010,
  parameter int          N_CHAN    = 4,
  parameter int          CNT_WIDTH = 32,
  parameter int          SATURATE  = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  counter_bank_register_if.slave bus,
  input  logic [N_CHAN-1:0]      increment
);

  logic [15:0]                          ofs;
  logic                                 in_rng, wr_hit;
  logic                                 snap_all, clr_all;
  logic [N_CHAN-1:0]                    en_q, en_d;
  logic [N_CHAN-1:0]                    ovf;
  logic [N_CHAN-1:0][CNT_WIDTH-1:0]     snap;
  logic [31:0]                          rd_data;

  // Decode; lower-bound test keeps addresses below BASE from aliasing via wrap
  assign ofs    = bus.reg_addr - BASE_ADDR;
  assign in_rng = (bus.reg_addr >= BASE_ADDR) && (ofs < 16'(CHAN_OFS + N_CHAN));
  assign wr_hit = bus.reg_wr & in_rng;

  assign snap_all = wr_hit && (ofs == 16'(CTRL_OFS)) && bus.reg_data[SNAP_BIT];
  assign clr_all  = wr_hit && (ofs == 16'(CTRL_OFS)) && bus.reg_data[CLEAR_BIT];

  // ENABLE next value; the write edge itself still counts with the old mask
  always_comb begin
    en_d = en_q;
    if (wr_hit && (ofs == 16'(ENABLE_OFS))) en_d = bus.reg_data[N_CHAN-1:0];
  end

  // ENABLE register, all channels on out of reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) en_q <= '1;
    else          en_q <= en_d;
  end

  for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
    chan_ctl_t ctl;
    assign ctl.inc     = increment[i];
    assign ctl.en      = en_q[i];
    assign ctl.clr     = clr_all | (wr_hit && (ofs == 16'(CHAN_OFS + i)));
    assign ctl.snap    = snap_all;
    assign ctl.ovf_clr = wr_hit && (ofs == 16'(OVF_OFS)) && bus.reg_data[i];

    counter_bank_channel #(
      .CNT_WIDTH (CNT_WIDTH),
      .SATURATE  (SATURATE)
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .ctl_i   (ctl),
      .snap_o  (snap[i]),
      .ovf_o   (ovf[i])
    );
  end

  // Read mux; reserved word and unused upper bits read 0
  always_comb begin
    rd_data = '0;
    if (ofs == 16'(CTRL_OFS))        rd_data = {16'h0, 8'(N_CHAN), 8'(CNT_WIDTH)};
    else if (ofs == 16'(ENABLE_OFS)) rd_data[N_CHAN-1:0] = en_q;
    else if (ofs == 16'(OVF_OFS))    rd_data[N_CHAN-1:0] = ovf;
    for (int i = 0; i < N_CHAN; i++)
      if (ofs == 16'(CHAN_OFS + i)) rd_data[CNT_WIDTH-1:0] = snap[i];
  end

  assign bus.rd_data = rd_data;
  assign bus.rd_oe   = in_rng & ~bus.reg_wr;

endmodule

// File: tb/tb_counter_bank_register.sv
// Directed bench: three banks (32-bit wrap, 4-bit wrap, 4-bit saturate)
// share one stimulus stream; each is read back independently.
module tb_counter_bank_register;

  logic       clk;
  logic       reset_n;
  logic [3:0] inc;
  int         n_chk = 0;
  int         n_err = 0;

  counter_bank_register_if if0();
  counter_bank_register_if if1();
  counter_bank_register_if if2();

  counter_bank_register #(.BASE_ADDR(16'h0010), .N_CHAN(4), .CNT_WIDTH(32), .SATURATE(0))
    u_d32 (.clk(clk), .reset_n(reset_n), .bus(if0), .increment(inc));
  counter_bank_register #(.BASE_ADDR(16'h0010), .N_CHAN(4), .CNT_WIDTH(4), .SATURATE(0))
    u_w4  (.clk(clk), .reset_n(reset_n), .bus(if1), .increment(inc));
  counter_bank_register #(.BASE_ADDR(16'h0010), .N_CHAN(4), .CNT_WIDTH(4), .SATURATE(1))
    u_s4  (.clk(clk), .reset_n(reset_n), .bus(if2), .increment(inc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       nm;
    logic [15:0] addr;
    logic        wr;
    logic [31:0] data;
    logic [3:0]  inc;
    int          dut;
    logic        chk;
    logic        exp_oe;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(string nm, logic [15:0] addr, logic wr, logic [31:0] data,
                              logic [3:0] vinc, int dut, logic chk, logic exp_oe,
                              logic [31:0] exp);
    vec_t v;
    v.nm = nm; v.addr = addr; v.wr = wr; v.data = data; v.inc = vinc;
    v.dut = dut; v.chk = chk; v.exp_oe = exp_oe; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic set_bus(input logic [15:0] a, input logic w, input logic [31:0] d);
    if0.reg_addr = a; if0.reg_wr = w; if0.wr_data = d; if0.wr_oe = w;
    if1.reg_addr = a; if1.reg_wr = w; if1.wr_data = d; if1.wr_oe = w;
    if2.reg_addr = a; if2.reg_wr = w; if2.wr_data = d; if2.wr_oe = w;
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bus write, taking effect on the next edge; increments keep their value
  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    set_bus(a, 1'b1, d);
    cyc(1);
    set_bus(16'h0000, 1'b0, 32'h0);
  endtask

  task automatic sample(input int d, output logic [31:0] v, output logic oe);
    #1;
    case (d)
      0:       begin v = if0.reg_data; oe = if0.rd_oe; end
      1:       begin v = if1.reg_data; oe = if1.rd_oe; end
      default: begin v = if2.reg_data; oe = if2.rd_oe; end
    endcase
  endtask

  // Combinational read (no clock edge) with value and drive-enable checks
  task automatic rd(input string nm, input int d, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] v;
    logic        oe;
    set_bus(a, 1'b0, 32'h0);
    sample(d, v, oe);
    chk({nm, ".oe"}, {31'h0, oe}, 32'h1);
    chk(nm, v, exp);
  endtask

  vec_t vq[$];

  initial begin
    logic [31:0] v;
    logic        oe;

    // Reset phase vectors, then 5 increments on ch0 and a SNAP
    vq.push_back(mk("rst_ctrl_d32",  16'h0010, 0, 0, 4'h0, 0, 1, 1, 32'h0000_0420));
    vq.push_back(mk("rst_ctrl_w4",   16'h0010, 0, 0, 4'h0, 1, 1, 1, 32'h0000_0404));
    vq.push_back(mk("rst_enable",    16'h0011, 0, 0, 4'h0, 0, 1, 1, 32'h0000_000F));
    vq.push_back(mk("rst_ovf",       16'h0012, 0, 0, 4'h0, 0, 1, 1, 32'h0));
    vq.push_back(mk("rst_snap0",     16'h0014, 0, 0, 4'h0, 0, 1, 1, 32'h0));
    vq.push_back(mk("rsvd_rd",       16'h0013, 0, 0, 4'h0, 0, 1, 1, 32'h0));
    vq.push_back(mk("idle_0000_oe",  16'h0000, 0, 0, 4'h1, 0, 1, 0, 32'h0));
    vq.push_back(mk("below_base_oe", 16'h000F, 0, 0, 4'h1, 1, 1, 0, 32'h0));
    vq.push_back(mk("past_end_oe",   16'h0018, 0, 0, 4'h1, 2, 1, 0, 32'h0));
    vq.push_back(mk("ffff_oe",       16'hFFFF, 0, 0, 4'h1, 0, 1, 0, 32'h0));
    vq.push_back(mk("high_oe",       16'h0110, 0, 0, 4'h1, 0, 1, 0, 32'h0));
    vq.push_back(mk("snap_wr",       16'h0010, 1, 1, 4'h0, 0, 0, 0, 32'h0));
    vq.push_back(mk("t1_snap0",      16'h0014, 0, 0, 4'h0, 0, 1, 1, 32'd5));
    vq.push_back(mk("t1_snap1",      16'h0015, 0, 0, 4'h0, 0, 1, 1, 32'd0));
    vq.push_back(mk("t1_ovf",        16'h0012, 0, 0, 4'h0, 0, 1, 1, 32'd0));
    vq.push_back(mk("t1_snap0_w4",   16'h0014, 0, 0, 4'h0, 1, 1, 1, 32'd5));
    vq.push_back(mk("t1_snap0_s4",   16'h0014, 0, 0, 4'h0, 2, 1, 1, 32'd5));
    vq.push_back(mk("rsvd_wr",       16'h0013, 1, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, 32'h0));
    vq.push_back(mk("rsvd_after_wr", 16'h0013, 0, 0, 4'h0, 0, 1, 1, 32'h0));
    vq.push_back(mk("enable_kept",   16'h0011, 0, 0, 4'h0, 0, 1, 1, 32'h0000_000F));

    inc = 4'h0;
    set_bus(16'h0000, 1'b0, 32'h0);
    reset_n = 1'b0;
    #12 reset_n = 1'b1;
    cyc(1);

    foreach (vq[i]) begin
      inc = vq[i].inc;
      set_bus(vq[i].addr, vq[i].wr, vq[i].data);
      if (vq[i].chk) begin
        sample(vq[i].dut, v, oe);
        chk({vq[i].nm, ".oe"}, {31'h0, oe}, {31'h0, vq[i].exp_oe});
        if (vq[i].exp_oe) chk(vq[i].nm, v, vq[i].exp);
      end
      cyc(1);
    end
    inc = 4'h0;
    set_bus(16'h0000, 1'b0, 32'h0);

    // Wrap / saturate: 17 total increments on ch0
    inc = 4'h1; cyc(12); inc = 4'h0;
    wr(16'h0010, 32'h1);
    rd("t2_snap0_d32", 0, 16'h0014, 32'd17);
    rd("t2_ovf_d32",   0, 16'h0012, 32'h0);
    rd("t2_snap0_w4",  1, 16'h0014, 32'd1);
    rd("t2_ovf_w4",    1, 16'h0012, 32'h1);
    rd("t2_snap0_s4",  2, 16'h0014, 32'd15);
    rd("t2_ovf_s4",    2, 16'h0012, 32'h1);
    wr(16'h0012, 32'h1);
    rd("t2_w1c_w4",    1, 16'h0012, 32'h0);
    rd("t2_w1c_s4",    2, 16'h0012, 32'h0);

    // Up to 20 increments: saturate re-flags overflow, wrap does not
    inc = 4'h1; cyc(3); inc = 4'h0;
    wr(16'h0010, 32'h1);
    rd("t3_snap0_s4",  2, 16'h0014, 32'd15);
    rd("t3_ovf_s4",    2, 16'h0012, 32'h1);
    rd("t3_snap0_w4",  1, 16'h0014, 32'd4);
    rd("t3_ovf_w4",    1, 16'h0012, 32'h0);
    rd("t3_snap0_d32", 0, 16'h0014, 32'd20);

    // W1C on the same edge as a saturating overflow: set wins
    inc = 4'h1;
    wr(16'h0012, 32'h1);
    inc = 4'h0;
    rd("w1c_vs_set_s4", 2, 16'h0012, 32'h1);

    // Atomic SNAP|CLEAR with increments running
    wr(16'h0010, 32'h2);
    inc = 4'h1; cyc(3);
    wr(16'h0010, 32'h3);
    rd("t4_snapclr",   0, 16'h0014, 32'd3);
    rd("t4_ovf_kept",  2, 16'h0012, 32'h1);
    cyc(3);
    wr(16'h0010, 32'h1);
    rd("t4_restart",   0, 16'h0014, 32'd3);
    inc = 4'h0;

    // ENABLE mask: write edge still uses the old mask
    wr(16'h0010, 32'h2);
    inc = 4'hF;
    wr(16'h0011, 32'h2);
    cyc(2);
    inc = 4'h0;
    wr(16'h0010, 32'h1);
    rd("t5_snap0", 0, 16'h0014, 32'd1);
    rd("t5_snap1", 0, 16'h0015, 32'd3);
    rd("t5_snap3", 0, 16'h0017, 32'd1);
    rd("t5_enable", 0, 16'h0011, 32'h2);
    set_bus(16'h0018, 1'b0, 32'h0);
    sample(0, v, oe);
    chk("t5_past_end_oe", {31'h0, oe}, 32'h0);

    // Per-channel clear: live ch1 cleared, SNAP_1 untouched, ch0 intact
    inc = 4'h2;
    wr(16'h0015, 32'h0);
    inc = 4'h0;
    rd("pclr_snap1_kept", 0, 16'h0015, 32'd3);
    wr(16'h0010, 32'h1);
    rd("pclr_snap1_zero", 0, 16'h0015, 32'd0);
    rd("pclr_snap0",      0, 16'h0014, 32'd1);

    // Async reset mid-count with OVF set
    rd("t6_pre_ovf", 2, 16'h0012, 32'h1);
    inc = 4'hF;
    cyc(2);
    #2 reset_n = 1'b0;
    rd("t6_snap0_d32", 0, 16'h0014, 32'd0);
    rd("t6_ovf_s4",    2, 16'h0012, 32'h0);
    rd("t6_enable",    0, 16'h0011, 32'h0000_000F);
    rd("t6_snap0_s4",  2, 16'h0014, 32'd0);
    #1 reset_n = 1'b1;
    inc = 4'h0;
    cyc(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
